// File: rtl/rmt_repair_ctrl_pkg.sv
// Shared definitions for the RMT repair controller: default geometry of the
// architectural/physical register files and the walk FSM state encoding.
package rmt_repair_ctrl_pkg;

  // Number of architectural registers (AMT/RMT entries)
  localparam int N_ARCH_REGS      = 34;
  // RMT repair lanes written per cycle
  localparam int N_REPAIR_PACKETS = 8;
  // Architectural register index width
  localparam int LOG_ARCH_REGS    = 6;
  // Physical register tag width
  localparam int PHY_REG_LOG      = 7;

  // Walk controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WALK  = 2'd1,
    DRAIN = 2'd2
  } repair_state_t;

  // Integer ceiling division, used to size the walk in beats
  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/rmt_repair_ctrl.sv
// RMT repair controller. On a recovery request it walks the AMT, reading
// N_PACKETS architectural entries per cycle through the AMT's combinational
// read ports, and replays them into the RMT repair port one beat later.
// The final beat may be partial: lanes beyond the last architectural
// register re-read the beat's lane 0 so every write in a beat is consistent.
module rmt_repair_ctrl
  import rmt_repair_ctrl_pkg::*;
#(
  parameter int N_ARCH_REGS = rmt_repair_ctrl_pkg::N_ARCH_REGS,
  parameter int N_PACKETS   = rmt_repair_ctrl_pkg::N_REPAIR_PACKETS,
  parameter int INDEX       = rmt_repair_ctrl_pkg::LOG_ARCH_REGS,
  parameter int WIDTH       = rmt_repair_ctrl_pkg::PHY_REG_LOG
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       recoverFlag_i,
  output logic [N_PACKETS*INDEX-1:0] amtAddr_o,
  input  logic [N_PACKETS*WIDTH-1:0] amtData_i,
  output logic                       repairFlag_o,
  output logic [N_PACKETS*INDEX-1:0] repairAddr_o,
  output logic [N_PACKETS*WIDTH-1:0] repairData_o,
  output logic                       repairBusy_o,
  output logic                       repairDone_o
);

  localparam int BEATS = ceil_div(N_ARCH_REGS, N_PACKETS);
  localparam int PTR_W = $clog2(BEATS + 1);
  localparam logic [PTR_W-1:0] LAST_BEAT = PTR_W'(BEATS - 1);

  repair_state_t    state;
  repair_state_t    next_state;
  logic [PTR_W-1:0] beat_ptr;
  logic [PTR_W-1:0] next_ptr;

  // Walk sequencing: a request from any state (re)starts the walk at beat 0;
  // the last WALK beat hands over to DRAIN, which presents the final
  // registered beat and then returns to IDLE.
  always_comb begin
    next_state = state;
    next_ptr   = beat_ptr;
    case (state)
      IDLE: begin
        next_ptr = '0;
        if (recoverFlag_i) begin
          next_state = WALK;
        end
      end
      WALK: begin
        if (recoverFlag_i) begin
          next_state = WALK;
          next_ptr   = '0;
        end else begin
          next_ptr = beat_ptr + PTR_W'(1);
          if (beat_ptr == LAST_BEAT) begin
            next_state = DRAIN;
          end
        end
      end
      DRAIN: begin
        next_ptr = '0;
        if (recoverFlag_i) begin
          next_state = WALK;
        end else begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
        next_ptr   = '0;
      end
    endcase
  end

  // State and beat pointer registers; reset abandons any walk in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      beat_ptr <= '0;
    end else begin
      state    <= next_state;
      beat_ptr <= next_ptr;
    end
  end

  // Per-lane AMT read address; lanes past the last architectural register
  // alias the beat's lane 0 so the duplicated RMT writes carry identical data
  for (genvar k = 0; k < N_PACKETS; k++) begin : g_lane
    logic [INDEX-1:0] lane_addr;

    // Lane address from state and beat pointer only; parked at 0 outside WALK
    always_comb begin
      lane_addr = '0;
      if (state == WALK) begin
        if ((int'(beat_ptr) * N_PACKETS + k) < N_ARCH_REGS) begin
          lane_addr = INDEX'(int'(beat_ptr) * N_PACKETS + k);
        end else begin
          lane_addr = INDEX'(int'(beat_ptr) * N_PACKETS);
        end
      end
    end

    assign amtAddr_o[k*INDEX +: INDEX] = lane_addr;
  end

  // Registered repair port: each WALK beat is captured and presented the next
  // cycle. A restart from DRAIN keeps the write enable up, re-presenting the
  // held final beat so the RMT sees no gap before the new walk's first beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      repairFlag_o <= 1'b0;
      repairBusy_o <= 1'b0;
      repairDone_o <= 1'b0;
      repairAddr_o <= '0;
      repairData_o <= '0;
    end else begin
      repairFlag_o <= (state == WALK) || ((state == DRAIN) && recoverFlag_i);
      repairBusy_o <= (next_state != IDLE);
      repairDone_o <= (next_state == DRAIN);
      if (state == WALK) begin
        repairAddr_o <= amtAddr_o;
        repairData_o <= amtData_i;
      end
    end
  end

endmodule

// File: tb/tb_rmt_repair_ctrl.sv
// Self-checking bench for rmt_repair_ctrl. A behavioural AMT answers the
// DUT's read ports; expected repair beats are queued when a recovery is
// requested and compared as the DUT presents them, while an RMT model
// collects the writes. A second instance covers the exact-multiple geometry.
module tb_rmt_repair_ctrl;

  localparam int NA      = 34;
  localparam int NP      = 8;
  localparam int IX      = 6;
  localparam int WD      = 7;
  localparam int BEATS   = 5;
  localparam int NA32    = 32;
  localparam int BEATS32 = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             recover;
  logic [NP*IX-1:0] amt_addr;
  logic [NP*WD-1:0] amt_data;
  logic             flag;
  logic [NP*IX-1:0] rep_addr;
  logic [NP*WD-1:0] rep_data;
  logic             busy;
  logic             done;

  logic             recover_32;
  logic [NP*IX-1:0] amt_addr_32;
  logic [NP*WD-1:0] amt_data_32;
  logic             flag_32;
  logic [NP*IX-1:0] rep_addr_32;
  logic [NP*WD-1:0] rep_data_32;
  logic             busy_32;
  logic             done_32;

  logic [63:0][WD-1:0] amt;
  logic [63:0][WD-1:0] rmt;

  typedef struct {
    int               beat;
    logic [NP*IX-1:0] addr;
    logic [NP*WD-1:0] data;
    logic             last;
  } beat_t;

  beat_t sb[$];
  beat_t mon_e;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rmt_repair_ctrl #(.N_ARCH_REGS(NA), .N_PACKETS(NP), .INDEX(IX), .WIDTH(WD)) dut (
    .clk          (clk),
    .reset        (rst_n),
    .recoverFlag_i(recover),
    .amtAddr_o    (amt_addr),
    .amtData_i    (amt_data),
    .repairFlag_o (flag),
    .repairAddr_o (rep_addr),
    .repairData_o (rep_data),
    .repairBusy_o (busy),
    .repairDone_o (done)
  );

  rmt_repair_ctrl #(.N_ARCH_REGS(NA32), .N_PACKETS(NP), .INDEX(IX), .WIDTH(WD)) dut32 (
    .clk          (clk),
    .reset        (rst_n),
    .recoverFlag_i(recover_32),
    .amtAddr_o    (amt_addr_32),
    .amtData_i    (amt_data_32),
    .repairFlag_o (flag_32),
    .repairAddr_o (rep_addr_32),
    .repairData_o (rep_data_32),
    .repairBusy_o (busy_32),
    .repairDone_o (done_32)
  );

  // Combinational AMT read ports for both instances
  always_comb begin
    for (int k = 0; k < NP; k++) begin
      amt_data[k*WD +: WD]    = amt[amt_addr[k*IX +: IX]];
      amt_data_32[k*WD +: WD] = amt[amt_addr_32[k*IX +: IX]];
    end
  end

  // Expected lane address: in range, or aliased to the beat's first entry
  function automatic int exp_lane_addr(input int beat, input int lane, input int n_regs);
    int a;
    a = beat * NP + lane;
    return (a < n_regs) ? a : beat * NP;
  endfunction

  // Queue every beat of a complete walk, data taken from the AMT as it is now
  task automatic push_walk();
    beat_t e;
    int a;
    for (int b = 0; b < BEATS; b++) begin
      e.beat = b;
      e.addr = '0;
      e.data = '0;
      for (int k = 0; k < NP; k++) begin
        a = exp_lane_addr(b, k, NA);
        e.addr[k*IX +: IX] = IX'(a);
        e.data[k*WD +: WD] = amt[a];
      end
      e.last = (b == BEATS - 1);
      sb.push_back(e);
    end
  endtask

  // Scoreboard: every presented beat must be the next queued one; the RMT
  // model takes the write the RMT would commit on the following edge
  always @(negedge clk) begin
    if (flag === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_beat: got addr=%h data=%h, required no beat", rep_addr, rep_data);
      end else begin
        mon_e = sb.pop_front();
        if (rep_addr !== mon_e.addr || rep_data !== mon_e.data || done !== mon_e.last) begin
          bad++;
          $display("[TB] FAIL beat_%0d: got addr=%h data=%h done=%b, required addr=%h data=%h done=%b",
                   mon_e.beat, rep_addr, rep_data, done, mon_e.addr, mon_e.data, mon_e.last);
        end
      end
      for (int k = 0; k < NP; k++) begin
        rmt[rep_addr[k*IX +: IX]] = rep_data[k*WD +: WD];
      end
    end
  end

  // Full uninterrupted walk on the 34-entry instance with window checks
  task automatic run_full_walk(input string tag);
    logic f_exp, b_exp, d_exp;
    int   a;
    @(posedge clk); #1;
    push_walk();
    recover = 1'b1;
    @(posedge clk); #1;
    recover = 1'b0;
    for (int c = 1; c <= BEATS + 3; c++) begin
      @(negedge clk);
      f_exp = (c >= 2) && (c <= BEATS + 1);
      b_exp = (c >= 1) && (c <= BEATS + 1);
      d_exp = (c == BEATS + 1);
      total++;
      if ({flag, busy, done} !== {f_exp, b_exp, d_exp}) begin
        bad++;
        $display("[TB] FAIL %s_cycle%0d: got flag/busy/done=%b%b%b, required %b%b%b",
                 tag, c, flag, busy, done, f_exp, b_exp, d_exp);
      end
      if (c == BEATS + 1) begin
        for (int k = 0; k < NP; k++) begin
          a = (k == 1) ? 33 : 32;
          total++;
          if (rep_addr[k*IX +: IX] !== IX'(a) || rep_data[k*WD +: WD] !== amt[a]) begin
            bad++;
            $display("[TB] FAIL %s_tail_lane%0d: got %0d/%0d, required %0d/%0d", tag, k,
                     rep_addr[k*IX +: IX], rep_data[k*WD +: WD], a, amt[a]);
          end
        end
      end
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("[TB] FAIL %s_pending: got %0d beats outstanding, required 0", tag, sb.size());
    end
  endtask

  task automatic test_reset();
    recover    = 1'b0;
    recover_32 = 1'b0;
    rst_n      = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if ({flag, busy, done, flag_32, busy_32, done_32} !== 6'b0) begin
      bad++;
      $display("[TB] FAIL reset_ctrl: got %b%b%b %b%b%b, required all 0",
               flag, busy, done, flag_32, busy_32, done_32);
    end
    total++;
    if (rep_addr !== '0 || rep_data !== '0 || amt_addr !== '0) begin
      bad++;
      $display("[TB] FAIL reset_data: got addr=%h data=%h amt=%h, required 0", rep_addr, rep_data, amt_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if ({flag, busy, flag_32, busy_32} !== 4'b0) begin
        bad++;
        $display("[TB] FAIL reset_release_%0d: got %b%b%b%b, required 0000", c, flag, busy, flag_32, busy_32);
      end
    end
  endtask

  task automatic test_basic_walk();
    rmt = '0;
    run_full_walk("basic");
    for (int i = 0; i < NA; i++) begin
      total++;
      if (rmt[i] !== amt[i]) begin
        bad++;
        $display("[TB] FAIL basic_rmt%0d: got %0d, required %0d", i, rmt[i], amt[i]);
      end
    end
  endtask

  task automatic test_restart();
    logic f_exp, d_exp;
    rmt = '0;
    @(posedge clk); #1;
    push_walk();
    recover = 1'b1;
    @(posedge clk); #1;
    recover = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk); #1;
    // Cycle 3 is WALK beat 2: beats 0..2 of the first walk still reach the RMT
    amt[5] = WD'(99);
    while (sb.size() > 0 && sb[$].beat > 2) void'(sb.pop_back());
    push_walk();
    recover = 1'b1;
    @(negedge clk);
    total++;
    if ({flag, busy, done} !== 3'b110) begin
      bad++;
      $display("[TB] FAIL restart_cycle3: got %b%b%b, required 110", flag, busy, done);
    end
    @(posedge clk); #1;
    recover = 1'b0;
    for (int c = 4; c <= 11; c++) begin
      @(negedge clk);
      f_exp = (c <= 3 + BEATS + 1);
      d_exp = (c == 3 + BEATS + 1);
      total++;
      if ({flag, busy, done} !== {f_exp, f_exp, d_exp}) begin
        bad++;
        $display("[TB] FAIL restart_cycle%0d: got %b%b%b, required %b%b%b",
                 c, flag, busy, done, f_exp, f_exp, d_exp);
      end
    end
    total++;
    if (rmt[5] !== WD'(99)) begin
      bad++;
      $display("[TB] FAIL restart_rmt5: got %0d, required 99", rmt[5]);
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("[TB] FAIL restart_pending: got %0d beats outstanding, required 0", sb.size());
    end
    amt[5] = WD'(45);
  endtask

  task automatic test_mid_reset();
    @(posedge clk); #1;
    push_walk();
    recover = 1'b1;
    @(posedge clk); #1;
    recover = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    total++;
    if ({flag, busy, done} !== 3'b0 || rep_addr !== '0 || rep_data !== '0 || amt_addr !== '0) begin
      bad++;
      $display("[TB] FAIL midreset_outputs: got %b%b%b addr=%h data=%h amt=%h, required all 0",
               flag, busy, done, rep_addr, rep_data, amt_addr);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++;
      if ({flag, busy, done} !== 3'b0) begin
        bad++;
        $display("[TB] FAIL midreset_after_%0d: got %b%b%b, required 000", c, flag, busy, done);
      end
    end
    run_full_walk("postreset");
  endtask

  task automatic test_idle();
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      total++;
      if ({flag, busy, done} !== 3'b0 || amt_addr !== '0) begin
        bad++;
        $display("[TB] FAIL idle_%0d: got %b%b%b amt=%h, required 000 amt=0", c, flag, busy, done, amt_addr);
      end
    end
  endtask

  task automatic test_exact_multiple();
    logic [NP*IX-1:0] ea;
    logic [NP*WD-1:0] ed;
    int seen;
    seen = 0;
    @(posedge clk); #1;
    recover_32 = 1'b1;
    @(posedge clk); #1;
    recover_32 = 1'b0;
    for (int c = 1; c <= BEATS32 + 4; c++) begin
      @(negedge clk);
      if (flag_32 === 1'b1) begin
        for (int k = 0; k < NP; k++) begin
          ea[k*IX +: IX] = IX'(seen * NP + k);
          ed[k*WD +: WD] = amt[seen * NP + k];
        end
        total++;
        if (rep_addr_32 !== ea || rep_data_32 !== ed || done_32 !== (seen == BEATS32 - 1)) begin
          bad++;
          $display("[TB] FAIL exact_beat%0d: got addr=%h data=%h done=%b, required addr=%h data=%h done=%b",
                   seen, rep_addr_32, rep_data_32, done_32, ea, ed, (seen == BEATS32 - 1));
        end
        seen++;
      end else begin
        total++;
        if (done_32 !== 1'b0) begin
          bad++;
          $display("[TB] FAIL exact_done_cycle%0d: got 1, required 0", c);
        end
      end
    end
    total++;
    if (seen != BEATS32) begin
      bad++;
      $display("[TB] FAIL exact_beats: got %0d, required %0d", seen, BEATS32);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    recover    = 1'b0;
    recover_32 = 1'b0;
    rmt        = '0;
    for (int i = 0; i < 64; i++) begin
      amt[i] = WD'(i + 40);
    end
    test_reset();
    test_basic_walk();
    test_restart();
    test_mid_reset();
    test_idle();
    test_exact_multiple();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
